sudoku_puzzle_gen: RTL and testbench

Sequential, parametrised successor to the combinational GameTemplate/MaskTemplate pair. On a start request it builds a canonical solved grid and applies a seeded sequence of validity-preserving permutations (digit relabel, row/column swap within band/stack, band/stack swap). It then blanks a runtime-selected number of cells and reports completion with a done pulse. It sits between random_gen (seed source) and the game/display logic.

---
 rtl/sudoku_pkg.sv | 52 +++++
 rtl/sudoku_lfsr32.sv | 37 +++
 rtl/sudoku_puzzle_gen.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_sudoku_puzzle_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// -----------------------------------------------------------------------------
// sudoku_pkg
//   Shared definitions for the Sudoku puzzle generator:
//   - grid geometry helpers (box side N -> SIDE, CELLS, CELL_W)
//   - controller state encoding and permutation op codes
//   - LFSR feedback mask, next-state helper and the zero-seed substitute
// -----------------------------------------------------------------------------
package sudoku_pkg;

    // Grid geometry derived from the box side N.
    function automatic int side_of(input int n);
        return n * n;
    endfunction

    function automatic int cells_of(input int n);
        return (n * n) * (n * n);
    endfunction

    // Digits 1..SIDE plus the value 0 need $clog2(SIDE+1) bits.
    function automatic int cell_w_of(input int n);
        return $clog2(n * n + 1);
    endfunction

    // Controller states. Encoding is fixed so dbg_state reads the same
    // in every build.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_SHUFFLE = 3'd2,
        ST_MASK    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Permutation op codes, taken from lfsr[2:0]; values 5..7 are rejected.
    typedef enum logic [2:0] {
        OP_DIGIT = 3'd0,   // relabel two digits everywhere
        OP_ROW   = 3'd1,   // swap two rows inside one band
        OP_COL   = 3'd2,   // swap two columns inside one stack
        OP_BAND  = 3'd3,   // swap two bands (groups of N rows)
        OP_STACK = 3'd4    // swap two stacks (groups of N columns)
    } op_e;

    localparam logic [31:0] LFSR_FB_MASK  = 32'h8020_0003;
    localparam logic [31:0] ZERO_SEED_SUB = 32'hACE1_1234;

    // Galois right-shift step: shift out bit 0, fold the mask back in when
    // the bit shifted out was 1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_FB_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/sudoku_lfsr32.sv
// -----------------------------------------------------------------------------
// sudoku_lfsr32
//   32-bit Galois LFSR used as the generator's random source.
//   Ports:
//     i_clk      clock
//     i_rst_n    synchronous active-low reset (state -> 0)
//     i_load     load i_load_val this cycle (has priority over i_en)
//     i_load_val value to load (caller guarantees non-zero)
//     i_en       advance one step this cycle
//     o_state    current LFSR state
// -----------------------------------------------------------------------------
module sudoku_lfsr32
    import sudoku_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    input  logic        i_en,
    output logic [31:0] o_state
);

    logic [31:0] r_state;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= 32'h0;
        end else if (i_load) begin
            r_state <= i_load_val;
        end else if (i_en) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/sudoku_puzzle_gen.sv
// -----------------------------------------------------------------------------
// sudoku_puzzle_gen
//   Builds a solved Sudoku grid from a seed and blanks a requested number of
//   cells. Flow: IDLE -> INIT (canonical grid) -> SHUFFLE (NUM_SWAPS accepted
//   validity-preserving permutations) -> MASK (blank cells) -> DONE -> IDLE.
//
//   Build option: define SYMMETRIC_MASK_EN to blank cells in point-symmetric
//   pairs (idx and CELLS-1-idx).
//
//   Parameters: N (box side), NUM_SWAPS (accepted permutations per game),
//               MAX_BLANKS (clamp for blanks_req, < CELLS)
//   Ports:
//     CLK_100MHz     clock
//     rst_n          synchronous active-low reset
//     start          new-game request (only honoured in IDLE)
//     seed           game seed, sampled with start (0 -> 32'hACE1_1234)
//     blanks_req     requested blank count, sampled with start
//     busy           high in INIT, SHUFFLE and MASK
//     done           one-cycle completion pulse
//     template_map   solved grid, cell r*SIDE+c at [i*CELL_W +: CELL_W]
//     template_mask  1 = visible cell, 0 = blank
//     dbg_state      current controller state
//
//   Handshake: start is a request strobe accepted only while the controller
//   is IDLE (busy=0 and done=0); once accepted, start is ignored until the
//   following done pulse. template_map/template_mask are valid from the done
//   pulse and hold until the next accepted start reaches INIT.
// -----------------------------------------------------------------------------
module sudoku_puzzle_gen
    import sudoku_pkg::*;
#(
    parameter int N          = 3,
    parameter int NUM_SWAPS  = 16,
    parameter int MAX_BLANKS = 64,
    localparam int SIDE      = side_of(N),
    localparam int CELLS     = cells_of(N),
    localparam int CELL_W    = cell_w_of(N),
    localparam int BLANK_W   = $clog2(CELLS + 1)
) (
    input  logic                      CLK_100MHz,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [31:0]               seed,
    input  logic [BLANK_W-1:0]        blanks_req,
    output logic                      busy,
    output logic                      done,
    output logic [CELLS*CELL_W-1:0]   template_map,
    output logic [CELLS-1:0]          template_mask,
    output state_e                    dbg_state
);

    localparam int IDX_W   = $clog2(CELLS);
    localparam int DIG_W   = (SIDE > 1) ? $clog2(SIDE) : 1;
    localparam int GRP_W   = (N > 1) ? $clog2(N) : 1;
    localparam int STEP_W  = (NUM_SWAPS > 0) ? $clog2(NUM_SWAPS + 1) : 1;

    // Operand field positions inside the LFSR word.
    localparam int OFF_DA  = 3;
    localparam int OFF_DB  = OFF_DA + DIG_W;
    localparam int OFF_G   = OFF_DB + DIG_W;
    localparam int OFF_X   = OFF_G + GRP_W;
    localparam int OFF_Y   = OFF_X + GRP_W;
    localparam int OFF_END = OFF_Y + GRP_W;

    // ---------------------------------------------------------------- state
    state_e                 r_state;
    state_e                 w_state_next;
    logic [CELL_W-1:0]      r_grid [CELLS];
    logic [CELL_W-1:0]      w_grid_shuf [CELLS];
    logic [CELLS-1:0]       r_mask;
    logic [BLANK_W-1:0]     r_blanks;
    logic [BLANK_W-1:0]     r_cnt;
    logic [STEP_W-1:0]      r_steps;

    logic [31:0]            w_lfsr;
    logic [31:0]            w_seed_eff;
    logic                   w_lfsr_load;
    logic                   w_lfsr_en;
    logic                   w_unused_lfsr;

    logic [2:0]             w_op;
    logic [DIG_W-1:0]       w_da;
    logic [DIG_W-1:0]       w_db;
    logic [GRP_W-1:0]       w_grp;
    logic [GRP_W-1:0]       w_x;
    logic [GRP_W-1:0]       w_y;
    logic                   w_shuf_ok;
    logic                   w_steps_done;
    logic [STEP_W-1:0]      w_steps_inc;

    logic [IDX_W-1:0]       w_idx;
    logic                   w_mask_ok;
    logic                   w_blanks_done;
    logic [1:0]             w_inc;
    logic [BLANK_W-1:0]     w_cnt_next;
    logic [BLANK_W-1:0]     w_blanks_clamped;

    // ---------------------------------------------------------------- LFSR
    assign w_seed_eff  = (seed == 32'h0) ? ZERO_SEED_SUB : seed;
    assign w_lfsr_load = (r_state == ST_IDLE) && start;
    assign w_lfsr_en   = (r_state == ST_INIT) || (r_state == ST_SHUFFLE) ||
                         (r_state == ST_MASK);

    sudoku_lfsr32 u_lfsr (
        .i_clk      (CLK_100MHz),
        .i_rst_n    (rst_n),
        .i_load     (w_lfsr_load),
        .i_load_val (w_seed_eff),
        .i_en       (w_lfsr_en),
        .o_state    (w_lfsr)
    );

    // Upper LFSR bits carry no operand; folded here so they count as read.
    assign w_unused_lfsr = ^w_lfsr[31:OFF_END];

    // ---------------------------------------------------------------- draws
    assign w_op  = w_lfsr[2:0];
    assign w_da  = w_lfsr[OFF_DA +: DIG_W];
    assign w_db  = w_lfsr[OFF_DB +: DIG_W];
    assign w_grp = w_lfsr[OFF_G  +: GRP_W];
    assign w_x   = w_lfsr[OFF_X  +: GRP_W];
    assign w_y   = w_lfsr[OFF_Y  +: GRP_W];
    assign w_idx = w_lfsr[IDX_W-1:0];

    assign w_blanks_clamped = (int'(blanks_req) > MAX_BLANKS) ?
                              BLANK_W'(MAX_BLANKS) : blanks_req;

    // A draw is usable only when every field it needs is in range.
    always_comb begin
        w_shuf_ok = 1'b0;
        case (w_op)
            OP_DIGIT:          w_shuf_ok = (int'(w_da) < SIDE) && (int'(w_db) < SIDE);
            OP_ROW, OP_COL:    w_shuf_ok = (int'(w_grp) < N) && (int'(w_x) < N) &&
                                           (int'(w_y) < N);
            OP_BAND, OP_STACK: w_shuf_ok = (int'(w_x) < N) && (int'(w_y) < N);
            default:           w_shuf_ok = 1'b0;
        endcase
    end

    assign w_steps_done = (r_steps == STEP_W'(NUM_SWAPS));
    assign w_steps_inc  = r_steps + STEP_W'(1);

    // Source line (row or column) for line i after a swap. in_grp swaps
    // lines x and y inside group g; grp_sw swaps whole groups x and y.
    function automatic int line_src(input int i, input logic in_grp, input logic grp_sw,
                                    input int g, input int x, input int y);
        int res;
        res = i;
        if (in_grp && (i / N == g)) begin
            if (i % N == x)      res = g * N + y;
            else if (i % N == y) res = g * N + x;
        end else if (grp_sw) begin
            if (i / N == x)      res = y * N + (i % N);
            else if (i / N == y) res = x * N + (i % N);
        end
        return res;
    endfunction

    // Digit relabel: values a+1 and b+1 trade places.
    function automatic logic [CELL_W-1:0] relabel(input logic [CELL_W-1:0] v, input logic en,
                                                  input int a, input int b);
        logic [CELL_W-1:0] res;
        res = v;
        if (en) begin
            if (int'(v) == a + 1)      res = CELL_W'(b + 1);
            else if (int'(v) == b + 1) res = CELL_W'(a + 1);
        end
        return res;
    endfunction

    // Every op is expressed as a gather through a row map, a column map and
    // a digit map; inactive maps are identity.
    always_comb begin
        for (int i = 0; i < CELLS; i++) begin
            w_grid_shuf[i] = r_grid[i];
        end
        for (int r = 0; r < SIDE; r++) begin
            for (int c = 0; c < SIDE; c++) begin
                w_grid_shuf[IDX_W'(r * SIDE + c)] = relabel(
                    r_grid[IDX_W'(
                        line_src(r, w_op == OP_ROW, w_op == OP_BAND,
                                 int'(w_grp), int'(w_x), int'(w_y)) * SIDE +
                        line_src(c, w_op == OP_COL, w_op == OP_STACK,
                                 int'(w_grp), int'(w_x), int'(w_y)))],
                    w_op == OP_DIGIT, int'(w_da), int'(w_db));
            end
        end
    end

    // ---------------------------------------------------------------- mask
`ifdef SYMMETRIC_MASK_EN
    logic [IDX_W-1:0] w_mirror;
    assign w_mirror = IDX_W'(CELLS - 1) - w_idx;
    // The centre cell is its own mirror and counts once.
    assign w_inc    = (w_idx == w_mirror) ? 2'd1 : 2'd2;
`else
    assign w_inc    = 2'd1;
`endif

    assign w_mask_ok     = (int'(w_idx) < CELLS) && r_mask[w_idx];
    assign w_blanks_done = (r_cnt >= r_blanks);
    assign w_cnt_next    = r_cnt + BLANK_W'(w_inc);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK_100MHz) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_next = ST_INIT;
            ST_INIT:    w_state_next = ST_SHUFFLE;
            ST_SHUFFLE: begin
                if (w_steps_done ||
                    (w_shuf_ok && (w_steps_inc == STEP_W'(NUM_SWAPS)))) begin
                    w_state_next = ST_MASK;
                end
            end
            ST_MASK: begin
                if (w_blanks_done || (w_mask_ok && (w_cnt_next >= r_blanks))) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge CLK_100MHz) begin
        if (!rst_n) begin
            for (int i = 0; i < CELLS; i++) begin
                r_grid[i] <= '0;
            end
            r_mask   <= '0;
            r_blanks <= '0;
            r_cnt    <= '0;
            r_steps  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_blanks <= w_blanks_clamped;
                        r_cnt    <= '0;
                        r_steps  <= '0;
                    end
                end
                ST_INIT: begin
                    // Canonical solved grid: each row is the previous one
                    // shifted by N, with an extra shift of 1 per band.
                    for (int r = 0; r < SIDE; r++) begin
                        for (int c = 0; c < SIDE; c++) begin
                            r_grid[IDX_W'(r * SIDE + c)] <=
                                CELL_W'(((r * N + r / N + c) % SIDE) + 1);
                        end
                    end
                    r_mask  <= '1;
                    r_cnt   <= '0;
                    r_steps <= '0;
                end
                ST_SHUFFLE: begin
                    if (!w_steps_done && w_shuf_ok) begin
                        for (int i = 0; i < CELLS; i++) begin
                            r_grid[i] <= w_grid_shuf[i];
                        end
                        r_steps <= w_steps_inc;
                    end
                end
                ST_MASK: begin
                    if (!w_blanks_done && w_mask_ok) begin
                        r_mask[w_idx] <= 1'b0;
`ifdef SYMMETRIC_MASK_EN
                        r_mask[w_mirror] <= 1'b0;
`endif
                        r_cnt <= w_cnt_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    assign busy          = (r_state == ST_INIT) || (r_state == ST_SHUFFLE) ||
                           (r_state == ST_MASK);
    assign done          = (r_state == ST_DONE);
    assign template_mask = r_mask;
    assign dbg_state     = r_state;

    always_comb begin
        template_map = '0;
        for (int i = 0; i < CELLS; i++) begin
            template_map[i * CELL_W +: CELL_W] = r_grid[IDX_W'(i)];
        end
    end

endmodule

// File: tb/tb_sudoku_puzzle_gen.sv
// -----------------------------------------------------------------------------
// tb_sudoku_puzzle_gen
//   Directed bench for sudoku_puzzle_gen at N=3. Two instances: dut0 with
//   NUM_SWAPS=0 (latency / canonical grid) and dut with NUM_SWAPS=16.
//   Expected blank counts are queued when a game is started and popped when
//   its done pulse arrives.
// -----------------------------------------------------------------------------
module tb_sudoku_puzzle_gen;
  import sudoku_pkg::*;

  localparam int SIDE   = 9;
  localparam int CELLS  = 81;
  localparam int CELL_W = 4;
  localparam int MAP_W  = CELLS * CELL_W;
  localparam int BW     = 7;
  localparam int BUDGET = 5000;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              start;
  logic              start0;
  logic [31:0]       seed;
  logic [BW-1:0]     blanks_req;
  logic              busy, done, busy0, done0;
  logic [MAP_W-1:0]  map, map0;
  logic [CELLS-1:0]  mask, mask0;
  state_e            st, st0;

  sudoku_puzzle_gen #(.N(3), .NUM_SWAPS(16), .MAX_BLANKS(64)) dut (
    .CLK_100MHz(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .blanks_req(blanks_req), .busy(busy), .done(done),
    .template_map(map), .template_mask(mask), .dbg_state(st)
  );

  sudoku_puzzle_gen #(.N(3), .NUM_SWAPS(0), .MAX_BLANKS(64)) dut0 (
    .CLK_100MHz(clk), .rst_n(rst_n), .start(start0), .seed(seed),
    .blanks_req(blanks_req), .busy(busy0), .done(done0),
    .template_map(map0), .template_mask(mask0), .dbg_state(st0)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Number of rows, columns and boxes that are not a permutation of 1..9.
  function automatic int bad_groups(input logic [MAP_W-1:0] m);
    int bad;
    bad = 0;
    for (int g = 0; g < SIDE; g++) begin
      logic [SIDE-1:0] sr, sc, sb;
      int vr, vc, vb, br, bc;
      sr = '0; sc = '0; sb = '0;
      for (int k = 0; k < SIDE; k++) begin
        vr = int'(m[(g * SIDE + k) * CELL_W +: CELL_W]);
        vc = int'(m[(k * SIDE + g) * CELL_W +: CELL_W]);
        br = (g / 3) * 3 + k / 3;
        bc = (g % 3) * 3 + k % 3;
        vb = int'(m[(br * SIDE + bc) * CELL_W +: CELL_W]);
        if (vr >= 1 && vr <= SIDE) sr[vr - 1] = 1'b1;
        if (vc >= 1 && vc <= SIDE) sc[vc - 1] = 1'b1;
        if (vb >= 1 && vb <= SIDE) sb[vb - 1] = 1'b1;
      end
      if (sr != '1) bad++;
      if (sc != '1) bad++;
      if (sb != '1) bad++;
    end
    return bad;
  endfunction

  function automatic logic mask_symmetric(input logic [CELLS-1:0] k);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < CELLS; i++) begin
      if (k[i] != k[CELLS - 1 - i]) ok = 1'b0;
    end
    return ok;
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_game(input logic [31:0] s, input logic [BW-1:0] req, input string tag,
                          output logic [MAP_W-1:0] m, output logic [CELLS-1:0] k);
    int cyc;
    int nb;
    logic [BW-1:0] e;
    seed = s;
    blanks_req = req;
    start = 1'b1;
    exp_q.push_back((req > 7'd64) ? 7'd64 : req);
    tick();
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < BUDGET) begin
      tick();
      cyc++;
    end
    check({tag, "_finished"}, 64'(cyc < BUDGET), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    m = map;
    k = mask;
    e = exp_q.pop_front();
    nb = $countones(~mask);
`ifdef SYMMETRIC_MASK_EN
    check({tag, "_blanks"}, 64'((nb == int'(e)) || (nb == int'(e) + 1)), 64'd1);
    check({tag, "_symmetric"}, 64'(mask_symmetric(mask)), 64'd1);
`else
    check({tag, "_blanks"}, 64'(nb), 64'(e));
`endif
    check({tag, "_valid"}, 64'(bad_groups(map)), 64'd0);
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [MAP_W-1:0] m_a, m_b, m_e, m_c, m_d, m_f, m_g, m_h;
  logic [CELLS-1:0] k_a, k_b, k_e, k_c, k_d, k_f, k_g, k_h;
  int lat, pulses, cyc;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start0 = 1'b0;
    seed = 32'h0;
    blanks_req = '0;
    repeat (3) tick();

    check("rst_state", 64'(st), 64'(ST_IDLE));
    check("rst_state0", 64'(st0), 64'(ST_IDLE));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_map_zero", 64'(map == '0), 64'd1);
    check("rst_mask_zero", 64'(mask == '0), 64'd1);
    rst_n = 1'b1;
    tick();

    // Minimum latency on the NUM_SWAPS=0 instance: canonical grid, no blanks.
    seed = 32'h1;
    blanks_req = '0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    lat = 1;
    check("lat_busy", 64'(busy0), 64'd1);
    while (done0 !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'd4);
    for (int c = 0; c < SIDE; c++) begin
      check("row0_cell", 64'(map0[c * CELL_W +: CELL_W]), 64'(c + 1));
    end
    check("cell9", 64'(map0[9 * CELL_W +: CELL_W]), 64'd4);
    check("cell80", 64'(map0[80 * CELL_W +: CELL_W]), 64'd8);
    check("mask0_all_ones", 64'(mask0 === {CELLS{1'b1}}), 64'd1);
    check("canonical_valid", 64'(bad_groups(map0)), 64'd0);
    tick();
    check("done0_one_cycle", 64'(done0), 64'd0);
    check("idle0_after_done", 64'(st0), 64'(ST_IDLE));

    // Shuffled games.
    run_game(32'h1, 7'd0, "seed1", m_a, k_a);
    check("seed1_mask_full", 64'(k_a === {CELLS{1'b1}}), 64'd1);
    run_game(32'hDEADBEEF, 7'd45, "beef", m_b, k_b);
    run_game(32'hDEADBEEF, 7'd45, "beef_again", m_e, k_e);
    check("repeat_map_same", 64'(m_e === m_b), 64'd1);
    check("repeat_mask_same", 64'(k_e === k_b), 64'd1);
    check("seeds_differ", 64'(m_a !== m_b), 64'd1);

    run_game(32'h0, 7'd20, "seed0", m_c, k_c);
    run_game(32'hACE11234, 7'd20, "seed_sub", m_d, k_d);
    check("zero_seed_map", 64'(m_c === m_d), 64'd1);
    check("zero_seed_mask", 64'(k_c === k_d), 64'd1);

    run_game(32'h12345678, 7'd80, "clamp", m_f, k_f);

    // start pulsed while busy must be ignored.
    run_game(32'h5, 7'd10, "clean5", m_g, k_g);
    seed = 32'h5;
    blanks_req = 7'd10;
    start = 1'b1;
    exp_q.push_back(7'd10);
    tick();
    seed = 32'h99;
    blanks_req = 7'd3;
    tick();
    tick();
    tick();
    start = 1'b0;
    pulses = 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < BUDGET) begin
      tick();
      cyc++;
    end
    check("ignore_finished", 64'(cyc < BUDGET), 64'd1);
    m_h = map;
    k_h = mask;
    check("ignore_blanks", 64'($countones(~k_h) >= int'(exp_q.pop_front())), 64'd1);
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    check("ignore_single_done", 64'(pulses), 64'd1);
    check("ignore_map_same", 64'(m_h === m_g), 64'd1);
    check("ignore_mask_same", 64'(k_h === k_g), 64'd1);

    // Reset while shuffling.
    seed = 32'h7;
    blanks_req = 7'd30;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (st !== ST_SHUFFLE && cyc < 20) begin
      tick();
      cyc++;
    end
    check("reached_shuffle", 64'(st), 64'(ST_SHUFFLE));
    rst_n = 1'b0;
    tick();
    check("midrst_state", 64'(st), 64'(ST_IDLE));
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_map_zero", 64'(map == '0), 64'd1);
    check("midrst_mask_zero", 64'(mask == '0), 64'd1);
    rst_n = 1'b1;
    tick();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
